// File: rtl/g9_pkg.sv
// Shared definitions for the G9 boot loader: memory geometry, frame length
// width and the loader state encoding.
package g9_pkg;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int LEN_W     = 16;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } ld_state_e;
endpackage

// File: rtl/byte_packer.sv
// 8->32 big-endian assembler: first byte lands in the MSBs. word_o and
// word_valid_o are registered, so the write pulse trails the 4th byte by one cycle.
module byte_packer
  import g9_pkg::*;
#(
  parameter int W = g9_pkg::WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_i,
  input  logic         byte_vld_i,
  output logic         last_byte_o,
  output logic         word_valid_o,
  output logic [W-1:0] word_o
);
  logic [1:0]   cnt_q;
  logic [W-9:0] asm_q;
  logic [W-1:0] word_q;
  logic         vld_q;

  assign last_byte_o  = (cnt_q == 2'd3);
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (byte_vld_i) begin
        cnt_q <= cnt_q + 2'd1;
        asm_q <= {asm_q[W-17:0], byte_i};
        if (cnt_q == 2'd3) begin
          word_q <= {asm_q, byte_i};
          vld_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory port A. Holds the core in
// reset until a frame with a matching XOR checksum has been written.
module imem_loader #(
  parameter int WORD_W = g9_pkg::WORD_W,
  parameter int ADDR_W = g9_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_wea,
  output logic [ADDR_W-1:0] imem_addra,
  output logic [WORD_W-1:0] imem_dina,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);
  import g9_pkg::*;

  localparam logic [LEN_W-1:0]  MAX_N = LEN_W'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   ONE_W = (ADDR_W+1)'(1);

  ld_state_e         state_q;
  logic [7:0]        len_hi_q;
  logic [7:0]        xor_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cpu_reset_q, done_q, err_q;

  logic             acc;
  logic [LEN_W-1:0] len_d;
  logic             last_byte;
  logic             word_valid;
  logic [7:0]       xor_d;

  assign rx_ready = ~reset & (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK});
  assign acc      = rx_valid & rx_ready;
  assign len_d    = {len_hi_q, rx_data};
  assign xor_d    = xor_q ^ rx_data;

  byte_packer #(.W(WORD_W)) u_pack (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (rx_data),
    .byte_vld_i   (acc && state_q == S_DATA),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (imem_dina)
  );

  assign imem_wea   = word_valid;
  assign imem_addra = addr_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      len_hi_q    <= '0;
      xor_q       <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (acc) begin
      case (state_q)
        S_LEN_HI: begin
          len_hi_q <= rx_data;
          xor_q    <= xor_d;
          state_q  <= S_LEN_LO;
        end
        S_LEN_LO: begin
          xor_q <= xor_d;
          len_q <= len_d[ADDR_W:0];
          if (len_d > MAX_N) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else if (len_d == '0) begin
            state_q <= S_CHECK;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          xor_q <= xor_d;
          if (last_byte) begin
            wcnt_q <= wcnt_q + ONE_W;
            if (wcnt_q + ONE_W == len_q) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rx_data == xor_q) begin
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Address advances on the edge that ends the write pulse, so it holds the
  // word index for the whole pulse.
  always_ff @(posedge clk) begin
    if (reset)           addr_q <= '0;
    else if (word_valid) addr_q <= addr_q + 1'b1;
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are modelled as byte
// lists, expected writes queued up front, and a monitor checks every pulse.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_wea;
  logic [8:0]  imem_addra;
  logic [31:0] imem_dina;
  logic        cpu_reset, load_done, load_error;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wbuf[$];
  int          n_vec = 0;
  int          n_bad = 0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_wea   (imem_wea),
    .imem_addra (imem_addra),
    .imem_dina  (imem_dina),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (imem_wea === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", imem_addra, imem_dina);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addra), 32'(e.addr));
        chk("wr_data", imem_dina, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
        chk("rdy_in_gap", 32'(rx_ready), 32'd1);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_wea",   32'(imem_wea), 32'd0);
    chk("rst_addr",  32'(imem_addra), 32'd0);
    chk("rst_dina",  imem_dina, 32'd0);
    chk("rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("rst_done",  32'(load_done), 32'd0);
    chk("rst_err",   32'(load_error), 32'd0);
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // chk_sel < 0: send the correct checksum; otherwise send chk_sel[7:0].
  task automatic run_frame(input int n, input int chk_sel, input bit gaps);
    logic [15:0] nn;
    logic [7:0]  x, c;
    logic [31:0] w;
    wr_t         e;
    bit          ok;
    nn = n[15:0];
    x  = nn[15:8] ^ nn[7:0];
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    if (n > 512) begin
      chk("ovf_err",    32'(load_error), 32'd1);
      chk("ovf_ready",  32'(rx_ready), 32'd0);
      chk("ovf_cpurst", 32'(cpu_reset), 32'd1);
      chk("ovf_done",   32'(load_done), 32'd0);
      repeat (3) @(negedge clk);
      return;
    end
    for (int i = 0; i < n; i++) begin
      e.addr = 9'(i);
      e.data = wbuf[i];
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      for (int k = 0; k < 4; k++) begin
        x = x ^ w[31-8*k -: 8];
        send_byte(w[31-8*k -: 8], gaps);
      end
    end
    c  = (chk_sel < 0) ? x : 8'(chk_sel);
    ok = (c == x);
    send_byte(c, gaps);
    chk("end_done",   32'(load_done), 32'(ok));
    chk("end_err",    32'(load_error), 32'(!ok));
    chk("end_cpurst", 32'(cpu_reset), 32'(!ok));
    chk("end_ready",  32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("hold_done",  32'(load_done), 32'(ok));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    int  n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed N=2, back-to-back, then with gaps.
    wbuf.delete(); wbuf.push_back(32'h11223344); wbuf.push_back(32'hA5A5A5A5);
    run_frame(2, -1, 1'b0);
    do_reset();
    run_frame(2, -1, 1'b1);

    do_reset();
    run_frame(513, -1, 1'b0);

    do_reset();
    wbuf.delete(); wbuf.push_back(32'hDEADBEEF);
    run_frame(1, 0, 1'b0);

    do_reset();
    wbuf.delete();
    run_frame(0, 0, 1'b0);

    // Reset after 2 bytes of word 1 in an N=3 frame.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    e.addr = 9'd0; e.data = 32'hCAFEF00D;
    exp_q.push_back(e);
    send_byte(8'hCA, 1'b0); send_byte(8'hFE, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h0D, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    do_reset();
    wbuf.delete(); wbuf.push_back(32'h0BADC0DE);
    run_frame(1, -1, 1'b0);

    // Full-capacity frame.
    do_reset();
    wbuf.delete();
    for (int i = 0; i < 512; i++) wbuf.push_back($urandom);
    run_frame(512, -1, 1'b0);

    // Random frames, occasional random checksum.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(1, 8);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back($urandom);
      run_frame(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1,
                1'($urandom_range(0, 1)));
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the G9 single-cycle core. It sits directly upstream of the instruction memory and receives a framed byte stream over a valid/ready handshake. It assembles the bytes into 32-bit big-endian instruction words and writes them through the instruction memory's port A (`wea`/`addra`/`dina`). The core's ProgramCounter is held in reset until a load completes with a verified checksum.

## Interface
- `WORD_W`, 32, instruction word width; fixed at 4 bytes.
- `ADDR_W`, 9, instruction memory address width; capacity 2**ADDR_W = 512 words.
- `clk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle; a byte transfers when `rx_valid & rx_ready`.
- `imem_wea` out 1: instruction memory write enable, one-cycle pulse per word.
- `imem_addra` out ADDR_W: word address.
- `imem_dina` out WORD_W: word to write.
- `cpu_reset` out 1: drives the ProgramCounter `reset`; high until the load succeeds.
- `load_done` out 1: load finished with checksum OK (sticky).
- `load_error` out 1: length overflow or checksum mismatch (sticky).

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N), then 4·N payload bytes (MSB first per word), then CHK.
- CHK is the XOR of every preceding frame byte, including both length bytes.
- States: S_LEN_HI → S_LEN_LO → S_DATA → S_CHECK → S_DONE | S_ERROR. S_DONE and S_ERROR are terminal until `reset`.
- S_LEN_LO, on byte accept:
  - N > 2**ADDR_W → S_ERROR.
  - N = 0 → S_CHECK.
  - Otherwise → S_DATA.
- S_DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On the 4th byte, the word is latched into `imem_dina`.
  - After the word of index N−1 completes, → S_CHECK.
- S_CHECK, on byte accept: byte equals the running XOR → S_DONE, else → S_ERROR.
- `rx_ready` = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CHECK; 0 in S_DONE, S_ERROR and while `reset` is high.
- Reset values: state S_LEN_HI, `imem_wea` 0, `imem_addra` 0, `imem_dina` 0, `cpu_reset` 1, `load_done` 0, `load_error` 0, XOR 0, word and byte counters 0.
- Reset mid-frame:
  - Discards the partial word, counters and XOR.
  - Words already written stay in memory.
  - The next byte accepted is treated as LEN_HI.

## Timing
- Back-to-back bytes are accepted every cycle; `rx_ready` never stalls inside the receiving states.
- `imem_wea` is high exactly one cycle: the cycle after the 4th byte of a word is accepted.
  - `imem_addra` holds that word's index during the pulse.
  - `imem_addra` increments on the following edge.
- Byte 0 of the next word can be accepted in the same cycle as the previous word's write pulse.
- State changes take effect on the edge following the deciding byte's acceptance.
- `cpu_reset` falls and `load_done` rises in the first cycle of S_DONE. The final write has always completed by then, because CHK is accepted no earlier than the last write cycle.
- `load_error` rises in the first cycle of S_ERROR; `cpu_reset` stays 1.
- The address never wraps: N ≤ 2**ADDR_W is enforced, so the maximum write address is 2**ADDR_W − 1.

## Structure
- Shared package `g9_pkg`:
  - loader state enum;
  - `WORD_W` and `ADDR_W` defaults (`MEM_WORDS` = 512);
  - `LEN_W` = 16.
- One sub-module, `byte_packer`:
  - 8→32 big-endian shift assembler with a byte counter;
  - outputs `word_valid` (one-cycle pulse) and `word`.
- The top level holds the FSM, word counter, XOR accumulator and output registers.

## Test plan
- N=2; words 0x11223344, 0xA5A5A5A5; bytes back-to-back; CHK=0x02^0x11^0x22^0x33^0x44 = 0x46 (the A5 bytes cancel) → write pulses at addr 0 then 1 with those words; `load_done`=1; `cpu_reset`=0 one cycle after CHK.
- Same frame with random `rx_valid` gaps → identical writes and outcome; `rx_ready` stays 1 throughout receiving.
- N=0x0201 (513) → S_ERROR after LEN_LO; `rx_ready`=0; `load_error`=1; `cpu_reset`=1; no `imem_wea`.
- N=1; word 0xDEADBEEF; CHK wrong (0x00) → one write at addr 0; `load_error`=1; `cpu_reset` stays 1.
- N=0, CHK=0x00 → `load_done`=1 with no writes.
- Reset after 2 bytes of word 1 in an N=3 frame, then a full N=1 frame → only addr 0 rewritten; the partial word is never written; the second frame completes with `load_done`.
